// File: rtl/snow64_lar_scoreboard_pkg.sv
// Shared constants and bundle types for the Snow64 LAR hazard scoreboard.
// Default geometry plus counter-width helper used by the top and its counters.
package snow64_lar_scoreboard_pkg;

    function automatic int cnt_width(int max_pending);
        return $clog2(max_pending + 1);
    endfunction

    localparam int DEF_NUM_LARS    = 16;
    localparam int DEF_NUM_SRC     = 3;
    localparam int DEF_MAX_PENDING = 3;
    localparam int DEF_WB_BYPASS   = 1;
    localparam int DEF_STALL_CNT_W = 16;
    localparam int DEF_IDX_W       = $clog2(DEF_NUM_LARS);
    localparam int DEF_CNT_W       = cnt_width(DEF_MAX_PENDING);

    typedef struct packed {
        logic [DEF_NUM_SRC*DEF_IDX_W-1:0] src_index;
        logic [DEF_NUM_SRC-1:0]           src_used;
        logic                             has_dst;
        logic [DEF_IDX_W-1:0]             dst_index;
    } issue_t;

    typedef struct packed {
        logic                 valid;
        logic [DEF_IDX_W-1:0] index;
    } wb_t;

endpackage

// File: rtl/snow64_lar_pending_counter.sv
// Per-LAR saturating up/down counter of in-flight write-backs.
// A decrement at zero is refused and reported as underflow instead.
module snow64_lar_pending_counter
    import snow64_lar_scoreboard_pkg::*;
#(
    parameter int MAX_PENDING = DEF_MAX_PENDING,
    parameter int CNT_W       = cnt_width(MAX_PENDING)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_PENDING);

    logic dec_ok;

    assign dec_ok    = dec && (count != '0);
    assign underflow = dec && (count == '0);

    always_comb begin
        count_nxt = count;
        if (clr)
            count_nxt = '0;
        else if (inc && !dec_ok && count != MAXC)
            count_nxt = count + CNT_W'(1);
        else if (dec_ok && !inc)
            count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/snow64_lar_scoreboard.sv
// Snow64 issue-side hazard scoreboard: pending-write counters per LAR,
// combinational issue gating, flush, WB bypass and stall statistics.
module snow64_lar_scoreboard
    import snow64_lar_scoreboard_pkg::*;
#(
    parameter int NUM_LARS    = DEF_NUM_LARS,
    parameter int NUM_SRC     = DEF_NUM_SRC,
    parameter int MAX_PENDING = DEF_MAX_PENDING,
    parameter int WB_BYPASS   = DEF_WB_BYPASS,
    parameter int STALL_CNT_W = DEF_STALL_CNT_W,
    localparam int IDX_W      = $clog2(NUM_LARS),
    localparam int CNT_W      = cnt_width(MAX_PENDING)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_issue_valid,
    input  logic [NUM_SRC*IDX_W-1:0] in_issue_src_index,
    input  logic [NUM_SRC-1:0]       in_issue_src_used,
    input  logic                     in_issue_has_dst,
    input  logic [IDX_W-1:0]         in_issue_dst_index,
    output logic                     out_issue_ready,
    input  logic                     in_wb_valid,
    input  logic [IDX_W-1:0]         in_wb_index,
    input  logic                     in_flush,
    output logic [NUM_LARS-1:0]      out_pending_mask,
    output logic [STALL_CNT_W-1:0]   out_stall_cycles,
    output logic                     out_wb_underflow
);

    localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0]   cnt     [NUM_LARS];
    logic [CNT_W-1:0]   cnt_nxt [NUM_LARS];
    logic [IDX_W-1:0]   sidx    [NUM_SRC];
    logic [NUM_LARS-1:0] byp;
    logic [NUM_LARS-1:0] uf;
    logic [NUM_LARS-1:0] mask_nxt;
    logic [NUM_SRC-1:0]  src_hz;
    logic                dst_hz;
    logic                dst_wb;
    logic                fire;

    assign cnt[0]      = '0;
    assign cnt_nxt[0]  = '0;
    assign byp[0]      = 1'b0;
    assign uf[0]       = 1'b0;
    assign mask_nxt[0] = 1'b0;

    // LAR 0 is the hardwired zero register and is never tracked
    for (genvar i = 1; i < NUM_LARS; i++) begin : g_lar
        assign byp[i] = (WB_BYPASS != 0) && in_wb_valid &&
                        (in_wb_index == IDX_W'(i)) && (cnt[i] == ONE);
        assign mask_nxt[i] = (cnt_nxt[i] != '0);

        snow64_lar_pending_counter #(
            .MAX_PENDING (MAX_PENDING),
            .CNT_W       (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .clr       (in_flush),
            .inc       (fire && in_issue_has_dst &&
                        (in_issue_dst_index == IDX_W'(i))),
            .dec       (in_wb_valid && (in_wb_index == IDX_W'(i))),
            .count     (cnt[i]),
            .count_nxt (cnt_nxt[i]),
            .underflow (uf[i])
        );
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign sidx[s]   = in_issue_src_index[s*IDX_W +: IDX_W];
        assign src_hz[s] = in_issue_src_used[s] && (sidx[s] != '0) &&
                           (cnt[sidx[s]] != '0) && !byp[sidx[s]];
    end

    // A full destination frees a slot when its own WB retires this cycle
    assign dst_wb = (WB_BYPASS != 0) && in_wb_valid &&
                    (in_wb_index == in_issue_dst_index);
    assign dst_hz = in_issue_has_dst && (in_issue_dst_index != '0) &&
                    (cnt[in_issue_dst_index] == MAXC) && !dst_wb;

    assign out_issue_ready = !in_flush && (src_hz == '0) && !dst_hz;
    assign fire = in_issue_valid && out_issue_ready && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_pending_mask <= '0;
            out_stall_cycles <= '0;
            out_wb_underflow <= 1'b0;
        end else begin
            out_pending_mask <= mask_nxt;
            if (in_issue_valid && !out_issue_ready && !in_flush &&
                out_stall_cycles != '1)
                out_stall_cycles <= out_stall_cycles + STALL_CNT_W'(1);
            if (!in_flush && (uf != '0))
                out_wb_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_snow64_lar_scoreboard.sv
// Scoreboard bench: driver pushes reference expectations, monitor compares.
// Reference keeps plain integer pending counts per LAR.
module tb_snow64_lar_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_issue_valid;
    logic [11:0] in_issue_src_index;
    logic [2:0]  in_issue_src_used;
    logic        in_issue_has_dst;
    logic [3:0]  in_issue_dst_index;
    logic        out_issue_ready;
    logic        in_wb_valid;
    logic [3:0]  in_wb_index;
    logic        in_flush;
    logic [15:0] out_pending_mask;
    logic [15:0] out_stall_cycles;
    logic        out_wb_underflow;

    snow64_lar_scoreboard dut (
        .clk                (clk),
        .rst                (rst),
        .in_issue_valid     (in_issue_valid),
        .in_issue_src_index (in_issue_src_index),
        .in_issue_src_used  (in_issue_src_used),
        .in_issue_has_dst   (in_issue_has_dst),
        .in_issue_dst_index (in_issue_dst_index),
        .out_issue_ready    (out_issue_ready),
        .in_wb_valid        (in_wb_valid),
        .in_wb_index        (in_wb_index),
        .in_flush           (in_flush),
        .out_pending_mask   (out_pending_mask),
        .out_stall_cycles   (out_stall_cycles),
        .out_wb_underflow   (out_wb_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rdy;
        bit [15:0] mask;
        int        stall;
        bit        uf;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    int m_cnt [16];
    int m_stall = 0;
    bit m_uf = 0;

    function automatic bit m_ready();
        int idx;
        if (in_flush) return 0;
        for (int s = 0; s < 3; s++) begin
            idx = int'(in_issue_src_index[s*4 +: 4]);
            if (in_issue_src_used[s] && idx != 0 && m_cnt[idx] != 0 &&
                !(in_wb_valid && int'(in_wb_index) == idx && m_cnt[idx] == 1))
                return 0;
        end
        if (in_issue_has_dst && in_issue_dst_index != 0 &&
            m_cnt[in_issue_dst_index] == 3 &&
            !(in_wb_valid && in_wb_index == in_issue_dst_index))
            return 0;
        return 1;
    endfunction

    function automatic bit [15:0] m_mask();
        bit [15:0] m = '0;
        for (int i = 1; i < 16; i++) m[i] = (m_cnt[i] != 0);
        return m;
    endfunction

    task automatic step(input bit v, input bit [11:0] src, input bit [2:0] used,
                        input bit hd, input bit [3:0] dst, input bit wv,
                        input bit [3:0] wi, input bit fl, input bit r);
        exp_t e;
        bit   rdy;
        @(negedge clk);
        in_issue_valid = v; in_issue_src_index = src; in_issue_src_used = used;
        in_issue_has_dst = hd; in_issue_dst_index = dst;
        in_wb_valid = wv; in_wb_index = wi; in_flush = fl; rst = r;
        #1;
        rdy = m_ready();
        e.rdy = rdy; e.mask = m_mask(); e.stall = m_stall; e.uf = m_uf;
        q.push_back(e);
        if (r) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_stall = 0; m_uf = 0;
        end else if (fl) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            if (v && !rdy && m_stall < 65535) m_stall++;
            if (wv && wi != 0) begin
                if (m_cnt[wi] == 0) m_uf = 1;
                else m_cnt[wi]--;
            end
            if (v && rdy && hd && dst != 0) m_cnt[dst]++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                compared++;
                if (out_issue_ready !== e.rdy) begin
                    mismatched++;
                    $display("FAIL ready @%0t got %b want %b", $time, out_issue_ready, e.rdy);
                end
                compared++;
                if (out_pending_mask !== e.mask) begin
                    mismatched++;
                    $display("FAIL mask @%0t got %h want %h", $time, out_pending_mask, e.mask);
                end
                compared++;
                if (int'(out_stall_cycles) != e.stall || $isunknown(out_stall_cycles)) begin
                    mismatched++;
                    $display("FAIL stall @%0t got %0d want %0d", $time, out_stall_cycles, e.stall);
                end
                compared++;
                if (out_wb_underflow !== e.uf) begin
                    mismatched++;
                    $display("FAIL underflow @%0t got %b want %b", $time, out_wb_underflow, e.uf);
                end
            end
        end
    end

    initial begin : driver
        bit [11:0] src;
        bit [3:0]  wi;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        rst = 1; in_issue_valid = 0; in_issue_src_index = 0; in_issue_src_used = 0;
        in_issue_has_dst = 0; in_issue_dst_index = 0; in_wb_valid = 0;
        in_wb_index = 0; in_flush = 0;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 5, 0, 0, 0, 0);
        idle(1);
        repeat (3) step(1, 12'h005, 3'b001, 0, 0, 0, 0, 0, 0);
        step(1, 12'h005, 3'b001, 0, 0, 1, 5, 0, 0);
        idle(2);
        repeat (4) step(1, 0, 0, 1, 7, 0, 0, 0, 0);
        step(1, 0, 0, 1, 7, 1, 7, 0, 0);
        idle(1);
        repeat (3) step(0, 0, 0, 0, 0, 1, 7, 0, 0);
        step(1, 0, 0, 1, 2, 0, 0, 0, 0);
        step(1, 0, 0, 1, 3, 0, 0, 0, 0);
        step(1, 0, 0, 1, 9, 0, 0, 0, 0);
        step(1, 12'h932, 3'b111, 1, 9, 1, 3, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 4, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        step(1, 12'h000, 3'b111, 1, 0, 0, 0, 0, 0);
        idle(1);
        for (int n = 0; n < 2000; n++) begin
            for (int s = 0; s < 3; s++) src[s*4 +: 4] = 4'($urandom_range(0, 15));
            wi = 4'($urandom_range(1, 15));
            for (int t = 0; t < 6 && m_cnt[wi] == 0; t++) wi = 4'($urandom_range(1, 15));
            step(1'($urandom_range(0, 1)), src, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 2) != 0), wi,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 300) == 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 5, 0, 0, 0, 0);
        repeat (70000) step(1, 12'h005, 3'b001, 0, 0, 0, 0, 0, 0);
        idle(2);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
